// File: rtl/mult_acc_32_signed_pkg.sv
// ---------------------------------------------------------------------------
// mult_acc_pkg
//   Shared definitions for the signed multiply-accumulate consumer:
//   default widths, FSM state encoding, saturation limits and the
//   product sign-extension helper.
// ---------------------------------------------------------------------------
package mult_acc_pkg;

    localparam int unsigned DEF_PROD_W = 32;
    localparam int unsigned DEF_ACC_W  = 40;
    localparam int unsigned DEF_OUT_W  = 32;
    localparam int unsigned DEF_CNT_W  = 8;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACCUM,
        ST_HOLD
    } state_t;

    localparam logic [DEF_OUT_W-1:0] SAT_MAX = {1'b0, {(DEF_OUT_W-1){1'b1}}};
    localparam logic [DEF_OUT_W-1:0] SAT_MIN = {1'b1, {(DEF_OUT_W-1){1'b0}}};

    // Sign-extend a product to accumulator width.
    function automatic logic [DEF_ACC_W-1:0] sext(input logic [DEF_PROD_W-1:0] p);
        return {{(DEF_ACC_W-DEF_PROD_W){p[DEF_PROD_W-1]}}, p};
    endfunction

endpackage

// File: rtl/mult_acc_32_signed_if.sv
// ---------------------------------------------------------------------------
// mult_acc_32_signed_if
//   Product input and sum output handshakes of the accumulator.
//   Product_/ProdValid/ProdReady : incoming signed product stream
//   Length_                      : terms per sum (0 = 2^CNT_W)
//   Sum_/SumValid/SumReady       : saturated sum stream
//   Overflow                     : sum was clipped (valid with SumValid)
//   Busy                         : accumulator is in ACCUM or HOLD
//   modport slave  : accumulator side
//   modport master : producer/consumer side
// ---------------------------------------------------------------------------
interface mult_acc_32_signed_if #(
    parameter int unsigned PROD_W = mult_acc_pkg::DEF_PROD_W,
    parameter int unsigned OUT_W  = mult_acc_pkg::DEF_OUT_W,
    parameter int unsigned CNT_W  = mult_acc_pkg::DEF_CNT_W
);

    logic [PROD_W-1:0] Product_;
    logic              ProdValid;
    logic              ProdReady;
    logic [CNT_W-1:0]  Length_;
    logic [OUT_W-1:0]  Sum_;
    logic              SumValid;
    logic              SumReady;
    logic              Overflow;
    logic              Busy;

    modport slave (
        input  Product_, ProdValid, Length_, SumReady,
        output ProdReady, Sum_, SumValid, Overflow, Busy
    );

    modport master (
        output Product_, ProdValid, Length_, SumReady,
        input  ProdReady, Sum_, SumValid, Overflow, Busy
    );

endinterface

// File: rtl/mult_acc_32_signed_sat_clip.sv
// ---------------------------------------------------------------------------
// sat_clip_40to32
//   Combinational signed clip of the ACC_W accumulator to OUT_W bits.
//   acc      in  ACC_W  signed accumulator value
//   sum      out OUT_W  clipped signed value
//   overflow out 1      acc was outside the OUT_W signed range
// ---------------------------------------------------------------------------
module sat_clip_40to32
    import mult_acc_pkg::*;
#(
    parameter int unsigned ACC_W = DEF_ACC_W,
    parameter int unsigned OUT_W = DEF_OUT_W
) (
    input  logic [ACC_W-1:0] acc,
    output logic [OUT_W-1:0] sum,
    output logic             overflow
);

    // The value fits when every bit from the output sign bit upward
    // equals the accumulator sign bit.
    logic fits;
    assign fits = (acc[ACC_W-1:OUT_W-1] == {(ACC_W-OUT_W+1){acc[ACC_W-1]}});

    always_comb begin
        sum      = acc[OUT_W-1:0];
        overflow = 1'b0;
        if (!fits) begin
            overflow = 1'b1;
            sum      = acc[ACC_W-1] ? SAT_MIN : SAT_MAX;
        end
    end

endmodule

// File: rtl/mult_acc_32_signed.sv
// ---------------------------------------------------------------------------
// mult_acc_32_signed
//   Accumulates Length_ signed products into a wide accumulator, then
//   presents the 32-bit saturated sum on a valid/ready handshake.
//   Clock  in  1  rising-edge system clock
//   Reset  in  1  synchronous active-high reset
//   bus    slave modport of mult_acc_32_signed_if (product in, sum out)
// ---------------------------------------------------------------------------
module mult_acc_32_signed
    import mult_acc_pkg::*;
#(
    parameter int unsigned PROD_W = DEF_PROD_W,
    parameter int unsigned ACC_W  = DEF_ACC_W,
    parameter int unsigned OUT_W  = DEF_OUT_W,
    parameter int unsigned CNT_W  = DEF_CNT_W
) (
    input  logic                  Clock,
    input  logic                  Reset,
    mult_acc_32_signed_if.slave   bus
);

    state_t            state;
    state_t            state_nxt;

    logic [ACC_W-1:0]  acc;
    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  cnt_inc;
    logic [CNT_W-1:0]  len;
    logic [OUT_W-1:0]  sum_q;
    logic              ovf_q;
    logic              sum_valid_q;

    logic              prod_ready;
    logic              busy;
    logic              prod_xfer;
    logic              sum_xfer;

    logic [OUT_W-1:0]  clip_sum;
    logic              clip_ovf;

    assign cnt_inc   = cnt + CNT_W'(1);
    assign prod_xfer = bus.ProdValid && prod_ready;
    assign sum_xfer  = sum_valid_q && bus.SumReady;

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge Clock) begin
        if (Reset) state <= ST_IDLE;
        else       state <= state_nxt;
    end

    // Terminal count compares in CNT_W arithmetic, so len=0 ends the sum
    // when the counter wraps, i.e. after 2^CNT_W terms.
    always_comb begin
        state_nxt  = state;
        prod_ready = 1'b0;
        busy       = 1'b0;
        unique case (state)
            ST_IDLE: begin
                prod_ready = !Reset;
                if (prod_xfer)
                    state_nxt = (bus.Length_ == CNT_W'(1)) ? ST_HOLD : ST_ACCUM;
            end
            ST_ACCUM: begin
                prod_ready = !Reset;
                busy       = 1'b1;
                if (prod_xfer && (cnt_inc == len))
                    state_nxt = ST_HOLD;
            end
            ST_HOLD: begin
                busy = 1'b1;
                if (sum_xfer)
                    state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath: counter, accumulator, output registers
    // ------------------------------------------------------------------
    // The clipped sum is captured on the first HOLD cycle from the settled
    // accumulator, which gives one cycle between last transfer and SumValid.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            acc         <= '0;
            cnt         <= '0;
            len         <= '0;
            sum_q       <= '0;
            ovf_q       <= 1'b0;
            sum_valid_q <= 1'b0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (prod_xfer) begin
                        len <= bus.Length_;
                        acc <= sext(bus.Product_);
                        cnt <= CNT_W'(1);
                    end
                end
                ST_ACCUM: begin
                    if (prod_xfer) begin
                        acc <= acc + sext(bus.Product_);
                        cnt <= cnt_inc;
                    end
                end
                ST_HOLD: begin
                    if (!sum_valid_q) begin
                        sum_q       <= clip_sum;
                        ovf_q       <= clip_ovf;
                        sum_valid_q <= 1'b1;
                    end else if (bus.SumReady) begin
                        sum_valid_q <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    sat_clip_40to32 #(
        .ACC_W (ACC_W),
        .OUT_W (OUT_W)
    ) u_sat (
        .acc      (acc),
        .sum      (clip_sum),
        .overflow (clip_ovf)
    );

    assign bus.ProdReady = prod_ready;
    assign bus.Busy      = busy;
    assign bus.Sum_      = sum_q;
    assign bus.Overflow  = ovf_q;
    assign bus.SumValid  = sum_valid_q;

endmodule

// File: tb/tb_mult_acc_32_signed.sv
// ---------------------------------------------------------------------------
// tb_mult_acc_32_signed
//   Directed and randomized sums checked against a plain-integer reference:
//   expected sum = saturate(sum of signed products).
// ---------------------------------------------------------------------------
module tb_mult_acc_32_signed;

    logic Clock;
    logic Reset;

    mult_acc_32_signed_if bus ();

    mult_acc_32_signed dut (
        .Clock (Clock),
        .Reset (Reset),
        .bus   (bus)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    int n_assert = 0;
    int n_fail   = 0;

    logic [31:0] q_terms[$];

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [32:0] ref_sat(input longint s);
        logic [63:0] u;
        u = s;
        if (s > 64'sd2147483647)       return {1'b1, 32'h7FFF_FFFF};
        else if (s < -64'sd2147483648) return {1'b1, 32'h8000_0000};
        else                           return {1'b0, u[31:0]};
    endfunction

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    // Offer one product and wait (bounded) for it to be accepted.
    task automatic xfer(input string tag, input logic [31:0] v);
        bit got;
        got = 1'b0;
        bus.ProdValid = 1'b1;
        bus.Product_  = v;
        for (int c = 0; c < 20 && !got; c++) begin
            #1;
            got = bus.ProdReady;
            tick();
        end
        if (!got) check({tag, "_accept_timeout"}, 64'd0, 64'd1);
        bus.ProdValid = 1'b0;
    endtask

    // Send every entry of q_terms as one sum and check the result.
    task automatic run_sum(input string tag, input int len_field, input int gap_max,
                           input int hold_cycles);
        longint     total;
        logic [32:0] exp;
        logic [31:0] held;
        total = 0;
        foreach (q_terms[i]) total += longint'($signed(q_terms[i]));
        exp = ref_sat(total);

        bus.SumReady = (hold_cycles == 0);
        bus.Length_  = 8'(len_field);
        foreach (q_terms[i]) begin
            int g;
            g = $urandom_range(0, gap_max);
            for (int k = 0; k < g; k++) tick();
            xfer(tag, q_terms[i]);
            // Length_ must only matter on the first transfer.
            bus.Length_ = 8'($urandom);
        end

        check({tag, "_valid_latency"}, bus.SumValid, 1'b0);
        check({tag, "_busy"}, bus.Busy, 1'b1);
        tick();
        check({tag, "_valid"}, bus.SumValid, 1'b1);
        check({tag, "_sum"}, bus.Sum_, exp[31:0]);
        check({tag, "_ovf"}, bus.Overflow, exp[32]);
        held = bus.Sum_;

        for (int k = 0; k < hold_cycles; k++) begin
            bus.ProdValid = 1'b1;
            bus.Product_  = $urandom;
            #1;
            check({tag, "_hold_ready"}, bus.ProdReady, 1'b0);
            tick();
            check({tag, "_hold_sum"}, bus.Sum_, held);
            check({tag, "_hold_valid"}, bus.SumValid, 1'b1);
        end
        bus.ProdValid = 1'b0;
        bus.SumReady  = 1'b1;
        tick();
        check({tag, "_done_valid"}, bus.SumValid, 1'b0);
        check({tag, "_done_busy"}, bus.Busy, 1'b0);
        #1;
        check({tag, "_idle_ready"}, bus.ProdReady, 1'b1);
    endtask

    initial begin
        Reset         = 1'b1;
        bus.Product_  = '0;
        bus.ProdValid = 1'b0;
        bus.Length_   = '0;
        bus.SumReady  = 1'b0;

        // Reset state
        tick();
        tick();
        check("rst_prodready", bus.ProdReady, 1'b0);
        check("rst_sum", bus.Sum_, 32'd0);
        check("rst_valid", bus.SumValid, 1'b0);
        check("rst_ovf", bus.Overflow, 1'b0);
        check("rst_busy", bus.Busy, 1'b0);
        Reset = 1'b0;
        #1;
        check("rst_release_ready", bus.ProdReady, 1'b1);

        // 1: 1+2+3+4 back to back
        q_terms = '{32'd1, 32'd2, 32'd3, 32'd4};
        run_sum("t1", 4, 0, 0);

        // 2: Length_=0 -> 256 terms of 2^30, positive clip
        q_terms.delete();
        for (int i = 0; i < 256; i++) q_terms.push_back(32'h4000_0000);
        run_sum("t2", 0, 0, 0);

        // 3: negative clip
        q_terms = '{32'hC000_8000, 32'hC000_8000, 32'hC000_8000};
        run_sum("t3", 3, 0, 0);

        // 4: -7 + 2 with consumer back-pressure
        q_terms = '{32'hFFFF_FFF9, 32'd2};
        run_sum("t4", 2, 0, 5);

        // 5: reset mid-sum discards partial sum
        bus.Length_ = 8'd4;
        xfer("t5", 32'd11);
        xfer("t5", 32'd22);
        Reset = 1'b1;
        #1;
        check("t5_rst_ready", bus.ProdReady, 1'b0);
        tick();
        check("t5_rst_sum", bus.Sum_, 32'd0);
        check("t5_rst_valid", bus.SumValid, 1'b0);
        check("t5_rst_ovf", bus.Overflow, 1'b0);
        check("t5_rst_busy", bus.Busy, 1'b0);
        Reset = 1'b0;
        q_terms = '{32'd5};
        run_sum("t5b", 1, 0, 0);

        // 6: ProdValid gaps
        q_terms = '{32'd100, 32'hFFFF_FFCE, 32'd25};
        run_sum("t6", 3, 3, 0);

        // Randomized sums, weighted towards extreme products
        for (int r = 0; r < 12; r++) begin
            int n;
            n = $urandom_range(1, 12);
            q_terms.delete();
            for (int i = 0; i < n; i++) begin
                case ($urandom_range(0, 3))
                    0: q_terms.push_back(32'h7FFF_FFFF - 32'($urandom_range(0, 255)));
                    1: q_terms.push_back(32'h8000_0000 + 32'($urandom_range(0, 255)));
                    default: q_terms.push_back($urandom);
                endcase
            end
            run_sum($sformatf("rnd%0d", r), n, 2, $urandom_range(0, 3));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
